// File: rtl/level_pattern_gen.sv
// level_pattern_gen
//
// Drives a single-bit level stream as a programmed train of low/high phases.
// Each low phase followed by a high phase forms one "0 then 1" event for the
// downstream level-trigger detector. A start/busy/done handshake controls it.
//
// Ports:
//   clk         single clock, all logic on its rising edge
//   reset       synchronous, active-high reset
//   start       request, sampled only while idle
//   low_len     cycles x_out is held low per pulse (0 behaves as 1)
//   high_len    cycles x_out is held high per pulse (0 behaves as 1)
//   num_pulses  number of low->high pulses to emit
//   x_out       generated level stream, registered, idles high
//   busy        high from the cycle after an accepted start through done
//   done        one-cycle completion pulse
//   pulse_cnt   rising edges emitted since the last accepted start

module level_pattern_gen #(
   parameter int LEN_W = 8,
   parameter int NUM_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] low_len,
   input  logic [LEN_W-1:0] high_len,
   input  logic [NUM_W-1:0] num_pulses,
   output logic             x_out,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] pulse_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      FINISH
   } state_t;

   state_t           state, state_next;
   logic [LEN_W-1:0] phase_cnt, phase_next;
   logic [NUM_W-1:0] remain_cnt, remain_next;
   logic [NUM_W-1:0] cnt_next;
   logic [LEN_W-1:0] low_q, low_next;
   logic [LEN_W-1:0] high_q, high_next;
   logic             x_next, busy_next, done_next;

   // The phase counter is loaded with (length - 1) and counts down to zero,
   // so a phase lasts exactly max(length, 1) cycles. A programmed length of
   // zero therefore behaves as a one-cycle phase.
   function automatic logic [LEN_W-1:0] len_minus_one(input logic [LEN_W-1:0] len);
      return (len == '0) ? '0 : len - LEN_W'(1);
   endfunction

   // Next-state logic. Every output is derived from the next state and then
   // registered, so x_out, busy and done change only on clock edges and
   // x_out makes exactly one transition at each phase boundary. The remaining
   // counter is decremented on entry to HIGH, which means that when a HIGH
   // phase ends with the counter at zero, the last pulse has been emitted.
   always_comb begin
      state_next  = state;
      phase_next  = phase_cnt;
      remain_next = remain_cnt;
      cnt_next    = pulse_cnt;
      low_next    = low_q;
      high_next   = high_q;

      case (state)
         IDLE: begin
            if (start) begin
               cnt_next = '0;
               if (num_pulses != '0) begin
                  low_next    = low_len;
                  high_next   = high_len;
                  remain_next = num_pulses;
                  phase_next  = len_minus_one(low_len);
                  state_next  = LOW;
               end else begin
                  state_next = FINISH;
               end
            end
         end

         LOW: begin
            if (phase_cnt == '0) begin
               state_next  = HIGH;
               phase_next  = len_minus_one(high_q);
               remain_next = remain_cnt - NUM_W'(1);
               if (pulse_cnt != '1) begin
                  cnt_next = pulse_cnt + NUM_W'(1);
               end
            end else begin
               phase_next = phase_cnt - LEN_W'(1);
            end
         end

         HIGH: begin
            if (phase_cnt == '0) begin
               if (remain_cnt != '0) begin
                  state_next = LOW;
                  phase_next = len_minus_one(low_q);
               end else begin
                  state_next = FINISH;
               end
            end else begin
               phase_next = phase_cnt - LEN_W'(1);
            end
         end

         FINISH: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      x_next    = (state_next != LOW);
      busy_next = (state_next != IDLE);
      done_next = (state_next == FINISH);
   end

   // State and output registers. Reset is synchronous and aborts any train
   // in progress: the outputs return to their idle values at the next edge
   // and no done pulse is produced.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         phase_cnt  <= '0;
         remain_cnt <= '0;
         pulse_cnt  <= '0;
         low_q      <= '0;
         high_q     <= '0;
         x_out      <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         phase_cnt  <= phase_next;
         remain_cnt <= remain_next;
         pulse_cnt  <= cnt_next;
         low_q      <= low_next;
         high_q     <= high_next;
         x_out      <= x_next;
         busy       <= busy_next;
         done       <= done_next;
      end
   end

endmodule

// File: tb/tb_level_pattern_gen.sv
// tb_level_pattern_gen
//
// Scoreboard bench for level_pattern_gen. Stimulus tasks push the expected
// per-cycle outputs (tagged with the cycle number they apply to) into a
// queue; a separate monitor pops and compares them on the falling edge.
// A small rising-edge detector stands in for the downstream level-trigger
// state machine and counts the "0 then 1" events on x_out.

module tb_level_pattern_gen;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] low_len;
   logic [7:0] high_len;
   logic [7:0] num_pulses;
   logic       x_out;
   logic       busy;
   logic       done;
   logic [7:0] pulse_cnt;

   typedef struct {
      int         cyc;
      logic       x;
      logic       busy;
      logic       done;
      logic [7:0] cnt;
   } exp_t;

   exp_t expQ[$];
   int   cyc;
   int   nCompared;
   int   nMismatched;
   int   detCount;
   logic prevX;

   level_pattern_gen #(
      .LEN_W(8),
      .NUM_W(8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .low_len    (low_len),
      .high_len   (high_len),
      .num_pulses (num_pulses),
      .x_out      (x_out),
      .busy       (busy),
      .done       (done),
      .pulse_cnt  (pulse_cnt)
   );

   // Free-running clock with a 10-time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter: the value seen during a cycle identifies that cycle.
   initial cyc = 0;
   always @(posedge clk) cyc++;

   // Model of the downstream level-trigger detector: one event per cycle
   // where x_out is high and was low in the previous cycle.
   initial prevX = 1'b1;
   always @(posedge clk) prevX <= x_out;
   always @(negedge clk) begin
      if (x_out === 1'b1 && prevX === 1'b0) detCount++;
   end

   // Monitor: compares every expectation whose cycle has arrived.
   always @(negedge clk) begin
      while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
         exp_t e;
         e = expQ.pop_front();
         nCompared++;
         if (e.cyc < cyc) begin
            nMismatched++;
            $display("[TB] FAIL missed_cycle: expectation for cycle %0d still queued at cycle %0d", e.cyc, cyc);
         end else if (x_out !== e.x || busy !== e.busy || done !== e.done || pulse_cnt !== e.cnt) begin
            nMismatched++;
            $display("[TB] FAIL cycle_%0d: got x=%b busy=%b done=%b cnt=%0d, expected x=%b busy=%b done=%b cnt=%0d",
                     cyc, x_out, busy, done, pulse_cnt, e.x, e.busy, e.done, e.cnt);
         end
      end
   end

   task automatic pushExp(input int c, input logic x, input logic b, input logic d, input int cnt);
      exp_t e;
      e.cyc  = c;
      e.x    = x;
      e.busy = b;
      e.done = d;
      e.cnt  = 8'(cnt);
      expQ.push_back(e);
   endtask

   // Expect n idle cycles starting with the current one.
   task automatic expectIdle(input int n, input int cnt);
      for (int k = 0; k < n; k++) pushExp(cyc + k, 1'b1, 1'b0, 1'b0, cnt);
   endtask

   // Wait (bounded) for the monitor to consume every expectation.
   task automatic checkOutput();
      int budget;
      budget = 40;
      while (expQ.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
         expQ.delete();
      end
   endtask

   // Start a train of n pulses (low l, high h). Cycle T+k is the cycle whose
   // counter value is base+k, where base is the cycle start is held in.
   // glitchAt>0 pulses start with other operands during cycle T+glitchAt;
   // resetAt>0 asserts reset during cycle T+resetAt.
   task automatic applyStimulus(input int l, input int h, input int n,
                                input int glitchAt, input int resetAt);
      int le, he, period, total, base, last, endK;
      le     = (l == 0) ? 1 : l;
      he     = (h == 0) ? 1 : h;
      period = le + he;
      total  = n * period;

      @(posedge clk);
      #1;
      base       = cyc;
      low_len    = 8'(l);
      high_len   = 8'(h);
      num_pulses = 8'(n);
      start      = 1'b1;
      detCount   = 0;

      last = (resetAt > 0) ? resetAt : total + 2;
      for (int k = 1; k <= last; k++) begin
         if (k <= total) begin
            int p, off;
            logic hi;
            p   = (k - 1) / period;
            off = (k - 1) % period;
            hi  = (off >= le);
            pushExp(base + k, hi, 1'b1, 1'b0, p + (hi ? 1 : 0));
         end else if (k == total + 1) begin
            pushExp(base + k, 1'b1, 1'b1, 1'b1, n);
         end else begin
            pushExp(base + k, 1'b1, 1'b0, 1'b0, n);
         end
      end
      if (resetAt > 0) begin
         for (int k = resetAt + 1; k <= resetAt + 6; k++) pushExp(base + k, 1'b1, 1'b0, 1'b0, 0);
      end else begin
         for (int k = total + 3; k <= total + 6; k++) pushExp(base + k, 1'b1, 1'b0, 1'b0, n);
      end

      endK = last + 6;
      for (int k = 1; k <= endK; k++) begin
         @(posedge clk);
         #1;
         low_len    = 8'd7;
         high_len   = 8'd9;
         num_pulses = 8'd5;
         start      = 1'b0;
         reset      = 1'b0;
         if (k == glitchAt) begin
            start      = 1'b1;
            low_len    = 8'd5;
            num_pulses = 8'd1;
         end
         if (k == resetAt) reset = 1'b1;
      end
      reset = 1'b0;
      start = 1'b0;
      checkOutput();

      if (resetAt == 0) begin
         nCompared++;
         if (detCount != n) begin
            nMismatched++;
            $display("[TB] FAIL detector_events: got %0d, expected %0d (L=%0d H=%0d)", detCount, n, l, h);
         end
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      detCount    = 0;
      reset       = 1'b1;
      start       = 1'b0;
      low_len     = 8'd0;
      high_len    = 8'd0;
      num_pulses  = 8'd0;

      repeat (3) @(posedge clk);
      #1;
      expectIdle(1, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      expectIdle(3, 0);
      checkOutput();

      $display("[TB] basic train L=2 H=3 N=2");
      applyStimulus(2, 3, 2, 0, 0);
      $display("[TB] zero lengths L=0 H=0 N=1");
      applyStimulus(0, 0, 1, 0, 0);
      $display("[TB] ignored start during run L=1 H=1 N=4");
      applyStimulus(1, 1, 4, 3, 0);
      $display("[TB] zero pulses N=0");
      applyStimulus(3, 3, 0, 0, 0);
      $display("[TB] reset in second HIGH phase L=4 H=4 N=3");
      applyStimulus(4, 4, 3, 0, 14);
      $display("[TB] fresh start after reset L=2 H=2 N=2");
      applyStimulus(2, 2, 2, 0, 0);
      $display("[TB] loopback L=1 H=2 N=3");
      applyStimulus(1, 2, 3, 0, 0);
      $display("[TB] loopback L=255 H=255 N=1");
      applyStimulus(255, 255, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
